// File: rtl/dbus_pkg.sv
// Shared encodings for the data-bus controller: request sizes, FSM states, lane masks.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package dbus_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Illegal size counts as misaligned so both cases share one error path.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lo[0];
            SZ_WORD: mis = (lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = BE_BYTE << lo;
            SZ_HALF: be = BE_HALF << lo;
            default: be = BE_WORD;
        endcase
        return be;
    endfunction

    // Replicating to every lane places the data under whichever lanes bus_be selects.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] w);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {4{w[7:0]}};
            SZ_HALF: d = {2{w[15:0]}};
            default: d = w;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dbus_ld_ext.sv
// Load lane extraction: shifts the addressed byte/half down and sign- or zero-extends it.
// Latency: purely combinational.
// Backpressure: none.
module dbus_ld_ext
    import dbus_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {addr_i, 3'b000};

    // Pick the width of the access and fill the upper bits with the extension bit.
    always_comb begin
        result_o = shifted;
        case (size_i)
            SZ_BYTE: result_o = {{24{~unsigned_i & shifted[7]}},  shifted[7:0]};
            SZ_HALF: result_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
            default: result_o = shifted;
        endcase
    end

endmodule

// File: rtl/dbus_ctrl.sv
// Data-bus controller: turns one mem_io load/store into a bus transaction and a response pulse.
// Latency: store 2 cycles, load 3 cycles minimum (accept to rsp_valid); misaligned error 1 cycle.
// Backpressure: req_ready only in IDLE; bus fields held stable while bus_ready is low.
module dbus_ctrl
    import dbus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_be,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata
);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [1:0]        lo_q, lo_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [DATA_W-1:0] ld_data;

    dbus_ld_ext u_ld_ext (
        .rdata_i    (bus_rdata),
        .addr_i     (lo_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .result_o   (ld_data)
    );

    // Next-state and capture logic; response fields default to zero so each pulse lasts one cycle.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        lo_d        = lo_q;
        size_d      = size_q;
        uns_d       = uns_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                    wdata_d = lane_wdata(req_size, req_wdata);
                    be_d    = lane_be(req_size, req_addr[1:0]);
                    lo_d    = req_addr[1:0];
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bus_ready) begin
                    if (we_q) begin
                        state_d     = IDLE;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus_rvalid) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = ld_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured-request registers; reset abandons any transaction in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            lo_q        <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            lo_q        <= lo_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Outputs are forced low while reset is held, even before the first reset edge lands.
    assign req_ready = (state_q == IDLE) && !reset;
    assign bus_valid = (state_q == REQ)  && !reset;
    assign bus_we    = we_q && !reset;
    assign bus_addr  = reset ? '0 : addr_q;
    assign bus_wdata = reset ? '0 : wdata_q;
    assign bus_be    = reset ? '0 : be_q;
    assign rsp_valid = rsp_valid_q && !reset;
    assign rsp_err   = rsp_err_q && !reset;
    assign rsp_rdata = reset ? '0 : rsp_rdata_q;

endmodule

// File: tb/tb_dbus_ctrl.sv
// Self-checking bench for dbus_ctrl: directed scenarios plus randomized transactions.
// Latency: checks exact store/load/error response cycles against a behavioural model.
// Backpressure: stalls bus_ready and delays bus_rvalid to exercise holding behaviour.
module tb_dbus_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        bus_valid, bus_ready, bus_we, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    dbus_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        return (sz == 2'd3) || (sz == 2'd1 && off % 2 != 0) || (sz == 2'd2 && off != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int nb;
        int off;
        logic [3:0] m;
        nb  = 1 << sz;
        off = int'(a % 4);
        m   = '0;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + nb) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] m_lanemask(input logic [3:0] be);
        logic [31:0] lm;
        lm = '0;
        for (int i = 0; i < 4; i++)
            if (be[i]) lm = lm | (32'hFF << (8 * i));
        return lm;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a,
                                           input logic uns, input logic [31:0] rd);
        int nb;
        logic [31:0] v;
        logic [31:0] keep;
        nb   = 1 << sz;
        v    = rd >> (8 * int'(a % 4));
        keep = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v    = v & keep;
        if (!uns && nb < 4 && v[8*nb-1]) v = v | ~keep;
        return v;
    endfunction

    // One full transaction from accept to response; starts and ends between negedges.
    task automatic run_txn(input string tag, input logic we, input logic [31:0] a,
                           input logic [31:0] w, input logic [1:0] sz, input logic uns,
                           input int stall, input int lat, input logic [31:0] rd);
        logic [3:0]  be;
        logic [31:0] lm;
        be = m_be(sz, a);
        lm = m_lanemask(be);
        @(negedge clock);
        check_eq({tag, ".ready"}, req_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = w;
        req_size = sz; req_unsigned = uns;
        @(negedge clock);
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_unsigned = 1'($urandom);
        if (m_misaligned(sz, a)) begin
            check_eq({tag, ".err_vld"}, rsp_valid, 1);
            check_eq({tag, ".err"}, rsp_err, 1);
            check_eq({tag, ".err_data"}, rsp_rdata, 0);
            check_eq({tag, ".err_nobus"}, bus_valid, 0);
            check_eq({tag, ".err_ready"}, req_ready, 1);
            @(negedge clock);
            check_eq({tag, ".err_once"}, rsp_valid, 0);
            check_eq({tag, ".err_nobus2"}, bus_valid, 0);
            return;
        end
        check_eq({tag, ".no_early_rsp"}, rsp_valid, 0);
        for (int i = 0; i <= stall; i++) begin
            check_eq({tag, ".bus_vld"}, bus_valid, 1);
            check_eq({tag, ".bus_addr"}, bus_addr, {a[31:2], 2'b00});
            check_eq({tag, ".bus_be"}, bus_be, be);
            check_eq({tag, ".bus_we"}, bus_we, we);
            if (we) check_eq({tag, ".bus_wdata"}, bus_wdata & lm, (w << (8 * int'(a % 4))) & lm);
            check_eq({tag, ".busy"}, req_ready, 0);
            bus_ready  = (i == stall);
            bus_rvalid = 1'($urandom);
            bus_rdata  = $urandom;
            @(negedge clock);
        end
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        if (!we) begin
            for (int i = 0; i < lat; i++) begin
                check_eq({tag, ".wait_rsp"}, rsp_valid, 0);
                check_eq({tag, ".wait_bus"}, bus_valid, 0);
                @(negedge clock);
            end
            bus_rvalid = 1'b1;
            bus_rdata  = rd;
            @(negedge clock);
            bus_rvalid = 1'b0;
            bus_rdata  = $urandom;
        end
        check_eq({tag, ".rsp_vld"}, rsp_valid, 1);
        check_eq({tag, ".rsp_err"}, rsp_err, 0);
        check_eq({tag, ".rsp_data"}, rsp_rdata, we ? 32'd0 : m_load(sz, a, uns, rd));
        @(negedge clock);
        check_eq({tag, ".rsp_once"}, rsp_valid, 0);
        check_eq({tag, ".idle_ready"}, req_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q[$];
        int acc;
        int acc_cyc[2];
        logic will_acc;

        reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40;
        req_wdata = 32'hFFFF_FFFF; req_size = 2'd2; req_unsigned = 1'b0;
        bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;

        // Reset state
        repeat (3) @(negedge clock);
        check_eq("rst.ready", req_ready, 0);
        check_eq("rst.rsp_vld", rsp_valid, 0);
        check_eq("rst.rsp_data", rsp_rdata, 0);
        check_eq("rst.rsp_err", rsp_err, 0);
        check_eq("rst.bus_vld", bus_valid, 0);
        check_eq("rst.bus_we", bus_we, 0);
        check_eq("rst.bus_addr", bus_addr, 0);
        check_eq("rst.bus_wdata", bus_wdata, 0);
        check_eq("rst.bus_be", bus_be, 0);
        req_valid = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check_eq("rst.ready_after", req_ready, 1);
        check_eq("rst.no_rsp_after", rsp_valid, 0);

        // Directed scenarios
        run_txn("word_store", 1'b1, 32'h100, 32'hDEAD_BEEF, 2'd2, 1'b0, 0, 0, 0);
        run_txn("byte_ld_s",  1'b0, 32'h203, 32'h0, 2'd0, 1'b0, 0, 4, 32'h80FF_FFFF);
        run_txn("byte_ld_u",  1'b0, 32'h203, 32'h0, 2'd0, 1'b1, 0, 4, 32'h80FF_FFFF);
        run_txn("misal_half", 1'b0, 32'h101, 32'h0, 2'd1, 1'b0, 0, 0, 0);
        run_txn("half_bp",    1'b1, 32'h102, 32'h1234, 2'd1, 1'b0, 5, 0, 0);
        run_txn("ill_size",   1'b1, 32'h200, 32'h55, 2'd3, 1'b0, 0, 0, 0);
        run_txn("half_ld_s",  1'b0, 32'h32, 32'h0, 2'd1, 1'b0, 1, 2, 32'h8001_7FFF);

        // Reset while waiting for load data; late rvalid must be ignored
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h300; req_size = 2'd2;
        @(negedge clock);
        req_valid = 1'b0; bus_ready = 1'b1;
        @(negedge clock);
        bus_ready = 1'b0;
        check_eq("rstw.in_wait", req_ready, 0);
        reset = 1'b1;
        @(negedge clock);
        check_eq("rstw.ready_low", req_ready, 0);
        check_eq("rstw.rsp_low", rsp_valid, 0);
        check_eq("rstw.bus_low", bus_valid, 0);
        reset = 1'b0;
        @(negedge clock);
        check_eq("rstw.ready_first", req_ready, 1);
        bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
        @(negedge clock);
        bus_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("rstw.no_rsp", rsp_valid, 0);
            check_eq("rstw.ready", req_ready, 1);
            @(negedge clock);
        end

        // Back-to-back word loads with req_valid held high
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h400; req_size = 2'd2; req_unsigned = 1'b0;
        bus_ready = 1'b1; bus_rvalid = 1'b1;
        acc = 0; acc_cyc[0] = 0; acc_cyc[1] = 0;
        will_acc = req_valid && req_ready;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (will_acc) begin
                if (acc < 2) acc_cyc[acc] = c;
                acc++;
                if (acc == 1) req_addr = 32'h804;
                else req_valid = 1'b0;
            end
            bus_rdata = bus_addr ^ 32'h5A5A_0000;
            if (rsp_valid) q.push_back(rsp_rdata);
            will_acc = req_valid && req_ready;
        end
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        check_eq("b2b.accepts", acc, 2);
        check_eq("b2b.gap", acc_cyc[1] - acc_cyc[0], 3);
        check_eq("b2b.nrsp", q.size(), 2);
        if (q.size() == 2) begin
            check_eq("b2b.rsp0", q[0], 32'h400 ^ 32'h5A5A_0000);
            check_eq("b2b.rsp1", q[1], 32'h804 ^ 32'h5A5A_0000);
        end

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            logic [31:0] a;
            a = $urandom;
            run_txn("rand", 1'($urandom), a, $urandom, 2'($urandom_range(0, 3)),
                    1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
